code_patch_ctrl: RTL and testbench

- Sequencer and lookup controller for the code-patch table used by the patch core.
- Holds NUM_ENTRIES patch entries (match address + patch word + valid) written over a config port.
- Serves serial-interface read requests by scanning the table one entry per cycle and returns hit/miss plus the patch word over a valid/ready response channel.
- Drives patch_enable_o and nopg_o toward the patch datapath.

---
 rtl/code_patch_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_code_patch_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_patch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : code_patch_ctrl
// Purpose  : Sequencer and lookup controller for the code-patch table.
//            Holds NUM_ENTRIES entries (match address, patch word, valid bit)
//            that are written through the config port. A read request from
//            the serial interface scans the table one entry per cycle,
//            ascending index. The hit/miss result and the patch word are
//            returned on a valid/ready response channel.
// Ports    : clk_i, rst_ni               clock, async active-low reset
//            cfg_*                       entry write port (cfg_ready_o = accept)
//            si_read_i/si_addr_i/si_ready_o  read request channel
//            rsp_valid_o/rsp_ready_i/rsp_hit_o/rsp_data_o  response channel
//            patch_enable_o              one-cycle pulse after an accepted
//                                        read while patch generation is on
//            nopg_o                      no valid entry, or generation off
//            stats_clr_i, hit_cnt_o      present only with CODE_PATCH_STATS_EN
// Options  : `define CODE_PATCH_STATS_EN adds a saturating 16-bit hit counter
// Revision : 1.0 - initial release
// ============================================================================
module code_patch_ctrl #(
  parameter int NUM_ENTRIES = 3,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 22,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_pat_gen_i,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic              cfg_vld_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  output logic              cfg_ready_o,
  input  logic              si_read_i,
  input  logic [ADDR_W-1:0] si_addr_i,
  output logic              si_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_hit_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              patch_enable_o,
  output logic              nopg_o
`ifdef CODE_PATCH_STATS_EN
  ,
  input  logic              stats_clr_i,
  output logic [15:0]       hit_cnt_o
`endif
);

  localparam logic [IDX_W:0]   c_num_entries = (IDX_W+1)'(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [ADDR_W-1:0]   r_lat_addr;
  logic                r_rsp_valid;
  logic                r_rsp_hit;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_patch_en;

  logic [NUM_ENTRIES-1:0] r_ent_vld;
  logic [ADDR_W-1:0]      r_ent_addr [NUM_ENTRIES];
  logic [DATA_W-1:0]      r_ent_data [NUM_ENTRIES];

  logic w_any_vld;
  logic w_accept;
  logic w_cfg_wr;
  logic w_scan_hit;

  assign w_any_vld   = |r_ent_vld;
  assign cfg_ready_o = (r_state == S_IDLE);
  // A config write takes precedence; a colliding read waits one cycle and
  // then observes the freshly written entry.
  assign si_ready_o  = (r_state == S_IDLE) & ~cfg_we_i;
  assign w_accept    = si_read_i & si_ready_o;
  // Out-of-range indices are handshaken but leave the table untouched.
  assign w_cfg_wr    = cfg_we_i & cfg_ready_o &
                       ({1'b0, cfg_idx_i} < c_num_entries);
  assign w_scan_hit  = r_ent_vld[r_idx] & (r_ent_addr[r_idx] == r_lat_addr);

  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_hit_o      = r_rsp_hit;
  assign rsp_data_o     = r_rsp_data;
  assign patch_enable_o = r_patch_en;
  assign nopg_o         = ~cfg_pat_gen_i | ~w_any_vld;

  // Patch table storage. Writes are only possible in IDLE, so the table is
  // stable for the whole duration of a scan.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ent_vld <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_ent_addr[i] <= '0;
        r_ent_data[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      r_ent_vld[cfg_idx_i]  <= cfg_vld_i;
      r_ent_addr[cfg_idx_i] <= cfg_addr_i;
      r_ent_data[cfg_idx_i] <= cfg_data_i;
    end
  end

  // Lookup sequencer. The generation enable is only consulted at the accept
  // edge, where it decides between an immediate miss and a scan, so later
  // changes cannot influence an in-flight lookup.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_lat_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
      r_patch_en  <= 1'b0;
    end else begin
      r_patch_en <= w_accept & cfg_pat_gen_i;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lat_addr <= si_addr_i;
            r_idx      <= '0;
            if (!cfg_pat_gen_i || !w_any_vld) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_hit   <= 1'b0;
              r_rsp_data  <= '0;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (w_scan_hit) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= 1'b1;
            r_rsp_data  <= r_ent_data[r_idx];
          end else if (r_idx == c_last_idx) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= 1'b0;
            r_rsp_data  <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_data  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CODE_PATCH_STATS_EN
  logic [15:0] r_hit_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hit_cnt <= '0;
    end else if (stats_clr_i) begin
      r_hit_cnt <= '0;
    end else if (r_rsp_valid && rsp_ready_i && r_rsp_hit &&
                 (r_hit_cnt != 16'hFFFF)) begin
      r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end

  assign hit_cnt_o = r_hit_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_code_patch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_patch_ctrl
// Purpose  : Self-checking bench for code_patch_ctrl. A table model inside
//            the bench predicts hit, patch word and response latency for
//            every read; directed scenarios are followed by a random mix of
//            writes and reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_patch_ctrl;

  localparam int NE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_pat_gen;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_vld;
  logic [12:0] cfg_addr;
  logic [21:0] cfg_data;
  logic        cfg_ready_o;
  logic        si_read;
  logic [12:0] si_addr;
  logic        si_ready_o;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic        rsp_hit_o;
  logic [21:0] rsp_data_o;
  logic        patch_enable_o;
  logic        nopg_o;
`ifdef CODE_PATCH_STATS_EN
  logic        stats_clr;
  logic [15:0] hit_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference table
  logic        m_vld  [NE];
  logic [12:0] m_addr [NE];
  logic [21:0] m_data [NE];
  int          m_hits;

  code_patch_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_pat_gen_i  (cfg_pat_gen),
    .cfg_we_i       (cfg_we),
    .cfg_idx_i      (cfg_idx),
    .cfg_vld_i      (cfg_vld),
    .cfg_addr_i     (cfg_addr),
    .cfg_data_i     (cfg_data),
    .cfg_ready_o    (cfg_ready_o),
    .si_read_i      (si_read),
    .si_addr_i      (si_addr),
    .si_ready_o     (si_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready),
    .rsp_hit_o      (rsp_hit_o),
    .rsp_data_o     (rsp_data_o),
    .patch_enable_o (patch_enable_o),
    .nopg_o         (nopg_o)
`ifdef CODE_PATCH_STATS_EN
    ,
    .stats_clr_i    (stats_clr),
    .hit_cnt_o      (hit_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int k = 0; k < NE; k++) begin
      m_vld[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0;
    end
    m_hits = 0;
  endfunction

  // Lookup outcome straight from the rules: immediate miss when generation
  // is off or the table is empty, else lowest matching valid index wins.
  function automatic void model_lookup(input logic [12:0] addr, input logic pg,
                                       output logic hit, output logic [21:0] data,
                                       output int lat);
    bit any;
    any = 0;
    hit = 1'b0;
    data = '0;
    for (int k = 0; k < NE; k++) if (m_vld[k]) any = 1;
    if (!pg || !any) begin
      lat = 1;
      return;
    end
    for (int k = 0; k < NE; k++) begin
      if (m_vld[k] && m_addr[k] == addr) begin
        hit = 1'b1; data = m_data[k]; lat = k + 2;
        return;
      end
    end
    lat = NE + 1;
  endfunction

  task automatic cfg_write(input int idx, input logic vld, input logic [12:0] addr,
                           input logic [21:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_vld = vld; cfg_addr = addr; cfg_data = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (idx < NE) begin
      m_vld[idx] = vld; m_addr[idx] = addr; m_data[idx] = data;
    end
  endtask

  // Issues a read, then flips the generation enable to prove the in-flight
  // lookup ignores it. Returns latency from accept edge (-1 on timeout).
  task automatic do_read(input logic [12:0] addr, input logic pg, output int lat,
                         output logic pe, output logic hit, output logic [21:0] data);
    int w;
    @(negedge clk);
    si_read = 1'b1; si_addr = addr; cfg_pat_gen = pg;
    #1;
    w = 0;
    while (!si_ready_o && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk);
    @(negedge clk);
    si_read = 1'b0;
    pe = patch_enable_o;
    cfg_pat_gen = ~pg;
    lat = 1;
    while (!rsp_valid_o && lat < 40) begin
      @(negedge clk); lat++;
    end
    if (!rsp_valid_o) lat = -1;
    hit = rsp_hit_o;
    data = rsp_data_o;
  endtask

  task automatic consume(input logic exp_hit);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (exp_hit) m_hits++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_pat_gen = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_vld = 1'b0;
    cfg_addr = '0; cfg_data = '0; si_read = 1'b0; si_addr = '0; rsp_ready = 1'b0;
`ifdef CODE_PATCH_STATS_EN
    stats_clr = 1'b0;
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid_o, rsp_hit_o, rsp_data_o, patch_enable_o, nopg_o, cfg_ready_o} !==
        {1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b hit=%b data=%h pe=%b nopg=%b cfg_rdy=%b, want 0 0 0 0 1 1",
               rsp_valid_o, rsp_hit_o, rsp_data_o, patch_enable_o, nopg_o, cfg_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_empty_miss();
    int lat; logic pe, hit; logic [21:0] data;
    @(negedge clk);
    cfg_pat_gen = 1'b1;
    #1;
    checks++;
    if (nopg_o !== 1'b1) begin
      errors++; $display("FAIL empty_nopg: got %b want 1", nopg_o);
    end
    do_read(13'h0100, 1'b1, lat, pe, hit, data);
    checks++;
    if (lat !== 1 || hit !== 1'b0 || data !== 22'h0) begin
      errors++;
      $display("FAIL empty_miss: got lat=%0d hit=%b data=%h want lat=1 hit=0 data=0", lat, hit, data);
    end
    checks++;
    if (pe !== 1'b1) begin
      errors++; $display("FAIL empty_patch_enable: got %b want 1", pe);
    end
    consume(1'b0);
  endtask

  task automatic test_single_hit();
    int lat; logic pe, hit; logic [21:0] data;
    cfg_write(1, 1'b1, 13'h0100, 22'h2AAAA);
    @(negedge clk);
    cfg_pat_gen = 1'b1;
    #1;
    checks++;
    if (nopg_o !== 1'b0) begin
      errors++; $display("FAIL single_nopg: got %b want 0", nopg_o);
    end
    do_read(13'h0100, 1'b1, lat, pe, hit, data);
    checks++;
    if (lat !== 3 || hit !== 1'b1 || data !== 22'h2AAAA) begin
      errors++;
      $display("FAIL single_hit: got lat=%0d hit=%b data=%h want lat=3 hit=1 data=2aaaa", lat, hit, data);
    end
    consume(1'b1);
    checks++;
    if (rsp_valid_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_release: got valid=%b cfg_rdy=%b want 0 1", rsp_valid_o, cfg_ready_o);
    end
  endtask

  task automatic test_collision();
    int lat, elat; logic pe, hit, ehit; logic [21:0] data, edata;
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_vld = 1'b1; cfg_addr = 13'h0055; cfg_data = 22'h00155;
    si_read = 1'b1; si_addr = 13'h0055; cfg_pat_gen = 1'b1;
    #1;
    checks++;
    if (si_ready_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL collision_ready: got si_rdy=%b cfg_rdy=%b want 0 1", si_ready_o, cfg_ready_o);
    end
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_vld[0] = 1'b1; m_addr[0] = 13'h0055; m_data[0] = 22'h00155;
    do_read(13'h0055, 1'b1, lat, pe, hit, data);
    model_lookup(13'h0055, 1'b1, ehit, edata, elat);
    checks++;
    if (lat !== elat || hit !== ehit || data !== edata) begin
      errors++;
      $display("FAIL collision_read: got lat=%0d hit=%b data=%h want lat=%0d hit=%b data=%h",
               lat, hit, data, elat, ehit, edata);
    end
    consume(ehit);
  endtask

  task automatic test_lowest_index();
    int lat; logic pe, hit; logic [21:0] data;
    cfg_write(0, 1'b1, 13'h0042, 22'h1);
    cfg_write(2, 1'b1, 13'h0042, 22'h3);
    do_read(13'h0042, 1'b1, lat, pe, hit, data);
    checks++;
    if (lat !== 2 || hit !== 1'b1 || data !== 22'h1) begin
      errors++;
      $display("FAIL lowest_index: got lat=%0d hit=%b data=%h want lat=2 hit=1 data=1", lat, hit, data);
    end
    consume(1'b1);
  endtask

  task automatic test_full_scan_miss();
    int lat; logic pe, hit; logic [21:0] data;
    // Index beyond the table must be ignored, so 0x777 stays absent.
    cfg_write(3, 1'b1, 13'h0777, 22'h3FFFFF);
    do_read(13'h0777, 1'b1, lat, pe, hit, data);
    checks++;
    if (lat !== NE + 1 || hit !== 1'b0 || data !== 22'h0) begin
      errors++;
      $display("FAIL full_scan_miss: got lat=%0d hit=%b data=%h want lat=%0d hit=0 data=0",
               lat, hit, data, NE + 1);
    end
    consume(1'b0);
  endtask

  task automatic test_pat_gen_off();
    int lat; logic pe, hit; logic [21:0] data;
    do_read(13'h0042, 1'b0, lat, pe, hit, data);
    checks++;
    if (lat !== 1 || hit !== 1'b0 || pe !== 1'b0) begin
      errors++;
      $display("FAIL pat_gen_off: got lat=%0d hit=%b pe=%b want lat=1 hit=0 pe=0", lat, hit, pe);
    end
    consume(1'b0);
  endtask

  task automatic test_backpressure();
    int lat; logic pe, hit; logic [21:0] data;
    do_read(13'h0100, 1'b1, lat, pe, hit, data);
    checks++;
    if (lat !== 3 || hit !== 1'b1 || data !== 22'h2AAAA) begin
      errors++;
      $display("FAIL backpressure_read: got lat=%0d hit=%b data=%h want lat=3 hit=1 data=2aaaa", lat, hit, data);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_hit_o !== 1'b1 || rsp_data_o !== 22'h2AAAA ||
          si_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d got valid=%b hit=%b data=%h si_rdy=%b want 1 1 2aaaa 0",
                 c, rsp_valid_o, rsp_hit_o, rsp_data_o, si_ready_o);
      end
    end
    consume(1'b1);
    checks++;
    if (rsp_valid_o !== 1'b0 || si_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got valid=%b si_rdy=%b want 0 1", rsp_valid_o, si_ready_o);
    end
  endtask

  task automatic test_random();
    int lat, elat; logic pe, hit, ehit, pg; logic [21:0] data, edata;
    logic [12:0] a;
    for (int n = 0; n < 40; n++) begin
      a = 13'h0010 + 13'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        cfg_write($urandom_range(0, NE), ($urandom_range(0, 3) != 0), a, 22'($urandom));
      end else begin
        pg = ($urandom_range(0, 4) != 0);
        model_lookup(a, pg, ehit, edata, elat);
        do_read(a, pg, lat, pe, hit, data);
        checks++;
        if (lat !== elat || hit !== ehit || data !== edata || pe !== pg) begin
          errors++;
          $display("FAIL random_read: addr=%h pg=%b got lat=%0d hit=%b data=%h pe=%b want lat=%0d hit=%b data=%h pe=%b",
                   a, pg, lat, hit, data, pe, elat, ehit, edata, pg);
        end
        consume(ehit);
      end
    end
  endtask

`ifdef CODE_PATCH_STATS_EN
  task automatic test_stats();
    #1;
    checks++;
    if (hit_cnt_o !== 16'(m_hits)) begin
      errors++; $display("FAIL stats_count: got %0d want %0d", hit_cnt_o, m_hits);
    end
    @(negedge clk);
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    m_hits = 0;
    checks++;
    if (hit_cnt_o !== 16'd0) begin
      errors++; $display("FAIL stats_clear: got %0d want 0", hit_cnt_o);
    end
  endtask
`endif

  task automatic test_reset_mid_scan();
    int lat; logic pe, hit; logic [21:0] data;
    cfg_write(2, 1'b1, 13'h0099, 22'h0ABCD);
    @(negedge clk);
    si_read = 1'b1; si_addr = 13'h0099; cfg_pat_gen = 1'b1;
    @(posedge clk);
    #1;
    si_read = 1'b0;
    @(negedge clk);
    checks++;
    if (patch_enable_o !== 1'b1 || rsp_valid_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_scan_state: got pe=%b valid=%b cfg_rdy=%b want 1 0 0",
               patch_enable_o, rsp_valid_o, cfg_ready_o);
    end
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({rsp_valid_o, rsp_hit_o, rsp_data_o, patch_enable_o, nopg_o, cfg_ready_o} !==
        {1'b0, 1'b0, 22'h0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mid_scan_reset: got valid=%b hit=%b data=%h pe=%b nopg=%b cfg_rdy=%b want 0 0 0 0 1 1",
               rsp_valid_o, rsp_hit_o, rsp_data_o, patch_enable_o, nopg_o, cfg_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_read(13'h0099, 1'b1, lat, pe, hit, data);
    checks++;
    if (lat !== 1 || hit !== 1'b0 || data !== 22'h0) begin
      errors++;
      $display("FAIL post_reset_read: got lat=%0d hit=%b data=%h want lat=1 hit=0 data=0", lat, hit, data);
    end
    consume(1'b0);
  endtask

  initial begin
    test_reset();
    test_empty_miss();
    test_single_hit();
    test_collision();
    test_lowest_index();
    test_full_scan_miss();
    test_pat_gen_off();
    test_backpressure();
    test_random();
`ifdef CODE_PATCH_STATS_EN
    test_stats();
`endif
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
